// File: rtl/sa_cache_wb_ctrl.sv
// Set-associative write-back, write-allocate cache controller.
// One CPU request is in flight at a time. A miss may write back a dirty victim,
// then fills the line and replays the lookup, which is then guaranteed to hit.
// Replacement uses per-way MRU bits: victim is the lowest invalid way, else the
// lowest way whose MRU bit is clear.
// Optional feature: define SA_CACHE_STATS_EN to add stat_hits/stat_misses
// (saturating counters of first-lookup outcomes; replays are not counted).
module sa_cache_wb_ctrl #(
   parameter int WAYS       = 4,
   parameter int SETS       = 256,
   parameter int LINE_BYTES = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cpu_req_valid,
   output logic                      cpu_req_ready,
   input  logic                      cpu_req_rw,
   input  logic [ADDR_WIDTH-1:0]     cpu_req_addr,
   input  logic [DATA_WIDTH-1:0]     cpu_req_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cpu_req_be,
   output logic                      cpu_resp_valid,
   output logic [DATA_WIDTH-1:0]     cpu_resp_rdata,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_rw,
   output logic [ADDR_WIDTH-1:0]     mem_req_addr,
   output logic [8*LINE_BYTES-1:0]   mem_req_wline,
   input  logic                      mem_resp_valid,
   input  logic [8*LINE_BYTES-1:0]   mem_resp_rline
`ifdef SA_CACHE_STATS_EN
   ,
   output logic [31:0]               stat_hits,
   output logic [31:0]               stat_misses
`endif
);

   localparam int OFFSET_BITS = $clog2(LINE_BYTES);
   localparam int INDEX_BITS  = $clog2(SETS);
   localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
   localparam int LINE_BITS   = 8 * LINE_BYTES;
   localparam int BE_BITS     = DATA_WIDTH / 8;
   localparam int BYTE_BITS   = $clog2(BE_BITS);
   localparam int WORDS       = LINE_BYTES / BE_BITS;
   localparam int WSEL_BITS   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int WAY_BITS    = $clog2(WAYS);

   typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT} state_t;

   state_t                        state_q, state_d;
   logic                          rw_q;
   logic [TAG_BITS-1:0]           tag_q;
   logic [INDEX_BITS-1:0]         index_q;
   logic [WSEL_BITS-1:0]          wsel_q;
   logic [DATA_WIDTH-1:0]         wdata_q;
   logic [BE_BITS-1:0]            be_q;
   logic                          replay_q;
   logic [WAY_BITS-1:0]           victim_q;
   logic                          resp_valid_q;
   logic [DATA_WIDTH-1:0]         resp_rdata_q;

   // Per-line state bits live in flops so they can be cleared by reset.
   logic [SETS-1:0][WAYS-1:0]     valid_q, dirty_q, mru_q;
   // Tags and data are plain arrays, never reset.
   logic [TAG_BITS-1:0]           tag_mem  [SETS][WAYS];
   logic [LINE_BITS-1:0]          data_mem [SETS][WAYS];

   logic [WAYS-1:0]               hit_vec;
   logic                          hit;
   logic [WAY_BITS-1:0]           hit_way, victim_sel;
   logic [WAYS-1:0]               mru_upd;
   logic [LINE_BITS-1:0]          hit_line;
   logic [DATA_WIDTH-1:0]         hit_word, merged_word;

   for (genvar gi = 0; gi < WAYS; gi++) begin : g_hit
      assign hit_vec[gi] = valid_q[index_q][gi] && (tag_mem[index_q][gi] == tag_q);
   end

   assign hit_line = data_mem[index_q][hit_way];
   assign hit_word = hit_line[wsel_q*DATA_WIDTH +: DATA_WIDTH];

   for (genvar gi = 0; gi < BE_BITS; gi++) begin : g_merge
      assign merged_word[gi*8 +: 8] = be_q[gi] ? wdata_q[gi*8 +: 8] : hit_word[gi*8 +: 8];
   end

   // Hit way, victim choice and the MRU pattern to store on a hit.
   always_comb begin
      hit        = |hit_vec;
      hit_way    = '0;
      victim_sel = '0;
      for (int w = WAYS-1; w >= 0; w--)
         if (hit_vec[w]) hit_way = WAY_BITS'(w);
      if (~&valid_q[index_q]) begin
         for (int w = WAYS-1; w >= 0; w--)
            if (!valid_q[index_q][w]) victim_sel = WAY_BITS'(w);
      end else begin
         for (int w = WAYS-1; w >= 0; w--)
            if (!mru_q[index_q][w]) victim_sel = WAY_BITS'(w);
      end
      mru_upd = mru_q[index_q] | (WAYS'(1) << hit_way);
      if (&mru_upd) mru_upd = WAYS'(1) << hit_way;
   end

   // Next-state logic and memory-side request outputs.
   always_comb begin
      state_d       = state_q;
      cpu_req_ready = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_rw    = 1'b0;
      mem_req_addr  = '0;
      mem_req_wline = '0;
      case (state_q)
         IDLE: begin
            cpu_req_ready = 1'b1;
            if (cpu_req_valid) state_d = LOOKUP;
         end
         LOOKUP: begin
            if (hit)
               state_d = IDLE;
            else if (valid_q[index_q][victim_sel] && dirty_q[index_q][victim_sel])
               state_d = WB;
            else
               state_d = FILL_REQ;
         end
         WB: begin
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b1;
            mem_req_addr  = {tag_mem[index_q][victim_q], index_q, {OFFSET_BITS{1'b0}}};
            mem_req_wline = data_mem[index_q][victim_q];
            if (mem_req_ready) state_d = FILL_REQ;
         end
         FILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {tag_q, index_q, {OFFSET_BITS{1'b0}}};
            if (mem_req_ready) state_d = FILL_WAIT;
         end
         FILL_WAIT: begin
            if (mem_resp_valid) state_d = LOOKUP;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state, request capture, line status bits and the response pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rw_q         <= 1'b0;
         tag_q        <= '0;
         index_q      <= '0;
         wsel_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         replay_q     <= 1'b0;
         victim_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
         mru_q        <= '0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         case (state_q)
            IDLE: if (cpu_req_valid) begin
               rw_q     <= cpu_req_rw;
               tag_q    <= cpu_req_addr[ADDR_WIDTH-1 -: TAG_BITS];
               index_q  <= cpu_req_addr[OFFSET_BITS +: INDEX_BITS];
               wsel_q   <= WSEL_BITS'(cpu_req_addr[OFFSET_BITS-1:0] >> BYTE_BITS);
               wdata_q  <= cpu_req_wdata;
               be_q     <= cpu_req_be;
               replay_q <= 1'b0;
            end
            LOOKUP: if (hit) begin
               resp_valid_q          <= 1'b1;
               resp_rdata_q          <= rw_q ? merged_word : hit_word;
               mru_q[index_q]        <= mru_upd;
               if (rw_q) dirty_q[index_q][hit_way] <= 1'b1;
            end else begin
               victim_q <= victim_sel;
            end
            WB: if (mem_req_ready) dirty_q[index_q][victim_q] <= 1'b0;
            FILL_WAIT: if (mem_resp_valid) begin
               valid_q[index_q][victim_q] <= 1'b1;
               dirty_q[index_q][victim_q] <= 1'b0;
               replay_q                   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Tag/data array writes: word merge on write hit, whole line on fill.
   always_ff @(posedge clk) begin
      if (state_q == LOOKUP && hit && rw_q)
         data_mem[index_q][hit_way][wsel_q*DATA_WIDTH +: DATA_WIDTH] <= merged_word;
      if (state_q == FILL_WAIT && mem_resp_valid) begin
         data_mem[index_q][victim_q] <= mem_resp_rline;
         tag_mem[index_q][victim_q]  <= tag_q;
      end
   end

   assign cpu_resp_valid = resp_valid_q;
   assign cpu_resp_rdata = resp_rdata_q;

`ifdef SA_CACHE_STATS_EN
   logic [31:0] hits_q, misses_q;

   // Count only the first lookup of each request; replays after a fill are skipped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else if (state_q == LOOKUP && !replay_q) begin
         if (hit && hits_q != 32'hFFFF_FFFF)    hits_q   <= hits_q + 32'd1;
         if (!hit && misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
      end
   end

   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_sa_cache_wb_ctrl.sv
// Self-checking bench for sa_cache_wb_ctrl (4 ways, 4 sets, 16-byte lines).
// Reference: a flat "truth" memory of what the CPU must observe, a backing
// memory image, and a per-set residency table driven by the replacement rules.
module tb_sa_cache_wb_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req_valid, cpu_req_ready, cpu_req_rw;
   logic [31:0]   cpu_req_addr, cpu_req_wdata;
   logic [3:0]    cpu_req_be;
   logic          cpu_resp_valid;
   logic [31:0]   cpu_resp_rdata;
   logic          mem_req_valid, mem_req_ready, mem_req_rw;
   logic [31:0]   mem_req_addr;
   logic [127:0]  mem_req_wline;
   logic          mem_resp_valid;
   logic [127:0]  mem_resp_rline;
`ifdef SA_CACHE_STATS_EN
   logic [31:0]   stat_hits, stat_misses;
`endif

   always #5 clk = ~clk;

   sa_cache_wb_ctrl #(
      .WAYS(4), .SETS(4), .LINE_BYTES(16), .ADDR_WIDTH(32), .DATA_WIDTH(32)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr),
      .cpu_req_wdata(cpu_req_wdata), .cpu_req_be(cpu_req_be),
      .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
      .mem_req_wline(mem_req_wline),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rline(mem_resp_rline)
`ifdef SA_CACHE_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
   );

   int checks = 0;
   int failures = 0;
   int txn = 0;

   logic [127:0] backing [64];
   logic [127:0] truth   [64];
   bit           mv [4][4];
   bit           md [4][4];
   bit           mm [4][4];
   int unsigned  mt [4][4];

   logic [31:0]  last_rdata;
   int           last_lat;
   bit           q_rw   [$];
   logic [31:0]  q_addr [$];
   logic [127:0] q_line [$];

   task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   function automatic void clear_model();
      for (int s = 0; s < 4; s++)
         for (int w = 0; w < 4; w++) begin
            mv[s][w] = 0; md[s][w] = 0; mm[s][w] = 0; mt[s][w] = 0;
         end
      for (int i = 0; i < 64; i++) truth[i] = backing[i];
   endfunction

   // Mark way used; if that would make every way recently used, keep only this one.
   function automatic void mru_touch(int s, int w);
      bit all1;
      mm[s][w] = 1;
      all1 = 1;
      for (int i = 0; i < 4; i++) if (!mm[s][i]) all1 = 0;
      if (all1) for (int i = 0; i < 4; i++) mm[s][i] = (i == w);
   endfunction

   task automatic do_reset();
      rst = 1; cpu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      clear_model();
      @(negedge clk);
   endtask

   task automatic access(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int stall, input bit noise);
      int s, w, vic, li, wi, vli, n, cyc, stall_left, fill_cd, fill_li;
      int unsigned tg;
      bit hit, done, seen, s_rw;
      logic [31:0]  exp_word, old, s_addr;
      logic [127:0] s_line;
      bit           e_rw   [$];
      logic [31:0]  e_addr [$];
      logic [127:0] e_line [$];

      // Reference prediction from the address, residency table and truth memory.
      s = int'((addr >> 4) & 3); tg = addr >> 6; li = int'(addr[9:4]); wi = int'(addr[3:2]);
      hit = 0; w = 0;
      for (int i = 3; i >= 0; i--) if (mv[s][i] && mt[s][i] == tg) begin hit = 1; w = i; end
      if (!hit) begin
         vic = -1;
         for (int i = 3; i >= 0; i--) if (!mv[s][i]) vic = i;
         if (vic < 0) for (int i = 3; i >= 0; i--) if (!mm[s][i]) vic = i;
         if (vic < 0) vic = 0;
         if (mv[s][vic] && md[s][vic]) begin
            vli = int'(mt[s][vic]) * 4 + s;
            e_rw.push_back(1); e_addr.push_back(32'(vli) << 4); e_line.push_back(truth[vli]);
            backing[vli] = truth[vli];
         end
         e_rw.push_back(0); e_addr.push_back({addr[31:4], 4'h0}); e_line.push_back('0);
         mv[s][vic] = 1; md[s][vic] = 0; mt[s][vic] = tg; w = vic;
      end
      old = truth[li][wi*32 +: 32];
      if (rw) begin
         for (int b = 0; b < 4; b++) exp_word[b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : old[b*8 +: 8];
         truth[li][wi*32 +: 32] = exp_word;
         md[s][w] = 1;
      end else begin
         exp_word = old;
      end
      mru_touch(s, w);

      // Drive the request and act as the memory.
      q_rw.delete(); q_addr.delete(); q_line.delete();
      @(negedge clk);
      cpu_req_valid = 1; cpu_req_rw = rw; cpu_req_addr = addr;
      cpu_req_wdata = wdata; cpu_req_be = be;
      n = 0;
      while (cpu_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("req_ready", cpu_req_ready, 1);
      @(negedge clk);
      cpu_req_valid = noise; cpu_req_rw = 1; cpu_req_addr = $urandom & 32'h3FC;
      cpu_req_wdata = $urandom; cpu_req_be = 4'hF;
      cyc = 1; done = 0; seen = 0; stall_left = stall; fill_cd = 0; fill_li = 0;
      s_rw = 0; s_addr = '0; s_line = '0;
      last_lat = -1; last_rdata = 'x;
      while (!done && cyc < 200) begin
         if (cpu_resp_valid === 1'b1) begin
            last_rdata = cpu_resp_rdata; last_lat = cyc; done = 1;
            cpu_req_valid = 0;
         end else begin
            chk("rdata_zero_when_idle", cpu_resp_rdata, 0);
         end
         mem_resp_valid = 0;
         if (fill_cd > 0) begin
            fill_cd--;
            if (fill_cd == 0) begin mem_resp_valid = 1; mem_resp_rline = backing[fill_li]; end
         end else if (noise && cyc == 1) begin
            mem_resp_valid = 1; mem_resp_rline = {$urandom, $urandom, $urandom, $urandom};
         end
         if (stall_left > 0 && seen) begin
            chk("stall_valid", mem_req_valid, 1);
            chk("stall_rw", mem_req_rw, s_rw);
            chk("stall_addr", mem_req_addr, s_addr);
            chk("stall_wline", mem_req_wline, s_line);
            chk("stall_cpu_ready", cpu_req_ready, 0);
            chk("stall_no_resp", cpu_resp_valid, 0);
         end
         if (mem_req_valid === 1'b1) begin
            if (stall_left > 0) begin
               if (!seen) begin s_rw = mem_req_rw; s_addr = mem_req_addr; s_line = mem_req_wline; end
               seen = 1; stall_left--; mem_req_ready = 0;
            end else begin
               mem_req_ready = 1;
               q_rw.push_back(mem_req_rw); q_addr.push_back(mem_req_addr); q_line.push_back(mem_req_wline);
               if (!mem_req_rw) begin fill_cd = 2; fill_li = int'(mem_req_addr[9:4]); end
            end
         end else begin
            mem_req_ready = 0;
         end
         if (!done) begin @(negedge clk); cyc++; end
      end
      mem_resp_valid = 0; mem_req_ready = 0; cpu_req_valid = 0;
      chk("resp_seen", done, 1);
      @(negedge clk);
      chk("resp_one_cycle", cpu_resp_valid, 0);
      chk("resp_rdata_cleared", cpu_resp_rdata, 0);

      chk("mem_req_count", q_rw.size(), e_rw.size());
      for (int i = 0; i < e_rw.size(); i++) begin
         if (i < q_rw.size()) begin
            chk("mem_req_rw", q_rw[i], e_rw[i]);
            chk("mem_req_addr", q_addr[i], e_addr[i]);
            if (e_rw[i]) chk("mem_req_wline", q_line[i], e_line[i]);
         end
      end
      chk("cpu_rdata", last_rdata, exp_word);
      if (hit) chk("hit_latency", last_lat, 2);
      txn++;
      $display("txn %0d rw=%0d addr=%h wdata=%h be=%h hit=%0d rdata=%h lat=%0d memreqs=%0d",
               txn, rw, addr, wdata, be, hit, last_rdata, last_lat, q_rw.size());
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1; cpu_req_valid = 0; cpu_req_rw = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
      cpu_req_be = '0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rline = '0;
      for (int i = 0; i < 64; i++) backing[i] = {$urandom, $urandom, $urandom, $urandom};
      backing[6'h10][63:32] = 32'hDEADBEEF;
      backing[6'h20][31:0]  = 32'hAABBCCDD;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_cpu_req_ready", cpu_req_ready, 1);
      chk("rst_resp_valid", cpu_resp_valid, 0);
      chk("rst_resp_rdata", cpu_resp_rdata, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_mem_req_rw", mem_req_rw, 0);
      chk("rst_mem_req_addr", mem_req_addr, 0);
      chk("rst_mem_req_wline", mem_req_wline, 0);
      do_reset();

      // Cold read miss, then hit on the same word
      access(0, 32'h104, 32'h0, 4'h0, 0, 0);
      chk("cold_fill_rw", q_rw.size() > 0 ? q_rw[0] : 1'b1, 0);
      chk("cold_fill_addr", q_addr.size() > 0 ? q_addr[0] : 32'hFFFF_FFFF, 32'h100);
      chk("cold_rdata", last_rdata, 32'hDEADBEEF);
      access(0, 32'h104, 32'h0, 4'h0, 0, 0);
      chk("warm_no_memreq", q_rw.size(), 0);
      chk("warm_latency", last_lat, 2);
      chk("warm_rdata", last_rdata, 32'hDEADBEEF);
`ifdef SA_CACHE_STATS_EN
      chk("stat_hits", stat_hits, 1);
      chk("stat_misses", stat_misses, 1);
`endif

      // Fill a set with dirty lines, force a writeback of way 0
      do_reset();
      access(1, 32'h000, $urandom, 4'hF, 0, 0);
      access(1, 32'h040, $urandom, 4'hF, 0, 0);
      access(1, 32'h080, $urandom, 4'hF, 0, 0);
      access(1, 32'h0C0, $urandom, 4'hF, 0, 0);
      access(0, 32'h100, 32'h0, 4'h0, 0, 0);
      chk("wb_rw", q_rw.size() > 0 ? q_rw[0] : 1'b0, 1);
      chk("wb_addr", q_addr.size() > 0 ? q_addr[0] : 32'hFFFF_FFFF, 32'h000);
      chk("wb_line", q_line.size() > 0 ? q_line[0] : '0, truth[0]);
      chk("wb_then_fill_rw", q_rw.size() > 1 ? q_rw[1] : 1'b1, 0);
      chk("wb_then_fill_addr", q_addr.size() > 1 ? q_addr[1] : 32'hFFFF_FFFF, 32'h100);

      // Writeback held off for 10 cycles
      access(0, 32'h140, 32'h0, 4'h0, 10, 0);
      chk("stall_wb_addr", q_addr.size() > 0 ? q_addr[0] : 32'hFFFF_FFFF, 32'h040);

      // Byte-enable merge on a resident word
      access(0, 32'h200, 32'h0, 4'h0, 0, 0);
      chk("merge_pre", last_rdata, 32'hAABBCCDD);
      access(1, 32'h200, 32'h12345678, 4'b0011, 0, 0);
      chk("merge_resp", last_rdata, 32'hAABB5678);
      access(0, 32'h200, 32'h0, 4'h0, 0, 0);
      chk("merge_readback", last_rdata, 32'hAABB5678);

      // Random traffic with back-pressure and ignored stray inputs
      for (int i = 0; i < 200; i++)
         access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) & 32'h3FC, $urandom,
                4'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

      // Reset while waiting for fill data
      do_reset();
      @(negedge clk);
      cpu_req_valid = 1; cpu_req_rw = 0; cpu_req_addr = 32'h2A4;
      @(negedge clk);
      cpu_req_valid = 0;
      n = 0;
      while (mem_req_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      chk("rstfw_fill_valid", mem_req_valid, 1);
      chk("rstfw_fill_addr", mem_req_addr, 32'h2A0);
      mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      chk("rstfw_in_fill_wait", cpu_req_ready, 0);
      #2 rst = 1;
      #1;
      chk("rstfw_cpu_ready", cpu_req_ready, 1);
      chk("rstfw_resp_valid", cpu_resp_valid, 0);
      chk("rstfw_resp_rdata", cpu_resp_rdata, 0);
      chk("rstfw_mem_valid", mem_req_valid, 0);
      chk("rstfw_mem_rw", mem_req_rw, 0);
      chk("rstfw_mem_addr", mem_req_addr, 0);
      chk("rstfw_mem_wline", mem_req_wline, 0);
      @(negedge clk);
      rst = 0;
      mem_resp_valid = 1; mem_resp_rline = {4{32'h5A5A_A5A5}};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("late_resp_no_cpu_resp", cpu_resp_valid, 0);
         chk("late_resp_no_mem_req", mem_req_valid, 0);
      end
      mem_resp_valid = 0;
      clear_model();
      access(0, 32'h2A4, 32'h0, 4'h0, 0, 0);
      chk("reread_misses", q_rw.size(), 1);
      chk("reread_fill_addr", q_addr.size() > 0 ? q_addr[0] : 32'hFFFF_FFFF, 32'h2A0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sa_cache_wb_ctrl.md
SA_CACHE_WB_CTRL -- requirements
Module: sa_cache_wb_ctrl

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity (power of 2, ≥2).
REQ-002 SHALL have parameter SETS, default 256, number of sets (power of 2).
REQ-003 SHALL have parameter LINE_BYTES, default 64, line size (power of 2, ≥ DATA_WIDTH/8).
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-005 SHALL have parameter DATA_WIDTH, default 32, CPU word width (multiple of 8).
REQ-006 SHALL derive OFFSET_BITS=clog2(LINE_BYTES), INDEX_BITS=clog2(SETS), TAG_BITS=ADDR_WIDTH-INDEX_BITS-OFFSET_BITS, LINE_BITS=8*LINE_BYTES.
REQ-007 SHALL have ports:
 clk  in  1  sole clock, rising edge
 rst  in  1  asynchronous, active-high reset
 cpu_req_valid  in  1  CPU request present
 cpu_req_ready  out  1  controller accepts request
 cpu_req_rw  in  1  1=write, 0=read
 cpu_req_addr  in  ADDR_WIDTH  byte address; low clog2(DATA_WIDTH/8) bits ignored
 cpu_req_wdata  in  DATA_WIDTH  write data
 cpu_req_be  in  DATA_WIDTH/8  write byte enables
 cpu_resp_valid  out  1  one-cycle response pulse
 cpu_resp_rdata  out  DATA_WIDTH  read word / merged written word
 mem_req_valid  out  1  memory request
 mem_req_ready  in  1  memory accepts request
 mem_req_rw  out  1  1=writeback, 0=line fill
 mem_req_addr  out  ADDR_WIDTH  line-aligned address
 mem_req_wline  out  LINE_BITS  writeback line
 mem_resp_valid  in  1  fill data valid
 mem_resp_rline  in  LINE_BITS  fill line

Function
REQ-008 SHALL store per set/way: valid, dirty, MRU bit, tag, line data.
REQ-009 SHALL implement FSM IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT; cpu_req_ready=1 only in IDLE.
REQ-010 SHALL latch addr/rw/wdata/be on cpu_req_valid&cpu_req_ready (cycle T) and enter LOOKUP at T+1.
REQ-011 SHALL, on LOOKUP hit (valid & tag match), read or byte-merge-write the word, set dirty on write, assert cpu_resp_valid at T+2 for exactly one cycle, return to IDLE.
REQ-012 SHALL, on hit, set way's MRU bit; if all MRU bits of the set would be 1, clear all others.
REQ-013 SHALL select victim on miss: lowest-index invalid way, else lowest-index way with MRU=0.
REQ-014 SHALL go LOOKUP→WB if victim valid&dirty, else →FILL_REQ.
REQ-015 SHALL, in WB, drive mem_req_rw=1, mem_req_addr={victim tag,index,0}, mem_req_wline=victim data; on mem_req_ready go FILL_REQ and clear victim dirty.
REQ-016 SHALL, in FILL_REQ, drive mem_req_rw=0, mem_req_addr={req tag,index,0}; on mem_req_ready go FILL_WAIT.
REQ-017 SHALL hold all mem_req_* outputs stable while mem_req_valid&!mem_req_ready.
REQ-018 SHALL, on mem_resp_valid in FILL_WAIT, install line in victim way (valid=1, dirty=0, new tag), then re-enter LOOKUP (guaranteed hit; write-allocate).
REQ-019 SHALL ignore mem_resp_valid outside FILL_WAIT and cpu_req_valid outside IDLE.
REQ-020 SHALL drive cpu_resp_rdata=0 whenever cpu_resp_valid=0.

Reset
REQ-021 SHALL, on rst, asynchronously force FSM=IDLE, all valid/dirty/MRU=0, cpu_resp_valid=0, cpu_resp_rdata=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_wline=0; data/tag arrays not reset.
REQ-022 SHALL abandon any in-flight transaction on reset mid-operation; a late mem_resp_valid SHALL be ignored.

Configuration
REQ-023 SHALL, with macro SA_CACHE_STATS_EN defined, add outputs stat_hits and stat_misses (32 bits each, reset 0, saturating) counting first-LOOKUP outcomes only (replay hits not counted); without it these ports and counters SHALL not exist and behaviour is otherwise identical.

Verification (WAYS=4, SETS=4, LINE_BYTES=16, DATA_WIDTH=32, ADDR_WIDTH=32)
REQ-024 Cold read 0x104 → fill request addr 0x100 rw=0; fill line word1=0xDEADBEEF → rdata 0xDEADBEEF; repeat read → resp at T+2, no mem request, stat_hits=1, stat_misses=1.
REQ-025 Write 0x12345678 be=4'b0011 to resident word 0xAABBCCDD → resp rdata 0xAABB5678; subsequent read returns 0xAABB5678.
REQ-026 Writes to 0x000,0x040,0x080,0x0C0 then read 0x100 → writeback rw=1 addr 0x000 with written line, then fill addr 0x100.
REQ-027 Hold mem_req_ready=0 for 10 cycles in WB → mem_req_valid/addr/wline constant, cpu_req_ready=0, no cpu_resp_valid.
REQ-028 Assert rst in FILL_WAIT → outputs at reset values immediately; later mem_resp_valid ignored; re-read same address misses.
